if_fetch: RTL and testbench
===========================

IF_FETCH -- requirements
Module: if_fetch

Interface
REQ-001 The block SHALL have these ports: clk  in  1  single clock, all state updates on posedge.
REQ-002 The block SHALL have these ports: rst  in  1  asynchronous, active-high reset.
REQ-003 The block SHALL have these ports: pc  in  32  current fetch address from PC register.
REQ-004 The block SHALL have these ports: redirect  in  1  next-PC is non-sequential (NPCOp != 0) this cycle.
REQ-005 The block SHALL have these ports: id_stall  in  1  decode cannot accept a new instruction.
REQ-006 The block SHALL have these ports: pc_stall  out  1  hold PC register.
REQ-007 The block SHALL have these ports: imem_req  out  1  fetch request valid.
REQ-008 The block SHALL have these ports: imem_addr  out  32  fetch address.
REQ-009 The block SHALL have these ports: imem_gnt  in  1  request accepted.
REQ-010 The block SHALL have these ports: imem_rvalid  in  1  response data valid.
REQ-011 The block SHALL have these ports: imem_rdata  in  32  response instruction word.
REQ-012 The block SHALL have these ports: if_valid  out  1  IF/ID register holds a live instruction.
REQ-013 The block SHALL have these ports: if_pc  out  32  address of held instruction.
REQ-014 The block SHALL have these ports: if_instr  out  32  held instruction word.
REQ-015 Parameter RESET_PC, default 32'h0000_0000, SHALL be the value of if_pc after reset.

Function
REQ-016 The FSM SHALL have states IDLE, REQ and WAIT, and SHALL allow at most one outstanding memory request.
REQ-017 IDLE SHALL last one cycle, then move to REQ.
REQ-018 In REQ: imem_req=1 and imem_addr=pc; on imem_gnt, latch pc into req_pc and go to WAIT.
REQ-019 In WAIT: imem_req=0 and imem_addr=req_pc.
REQ-020 slot_free SHALL be ~if_valid | ~id_stall.
REQ-021 accept SHALL be (state==WAIT) & imem_rvalid & ~discard & slot_free.
REQ-022 On accept: if_instr<=imem_rdata, if_pc<=req_pc, if_valid<=1, next state REQ.
REQ-023 When WAIT & imem_rvalid & ~discard & ~slot_free, the block SHALL stay in WAIT with the response dropped and SHALL re-issue (state REQ with the same req_pc) on the next cycle; no instruction is lost because PC has not advanced.
REQ-024 pc_stall SHALL be combinational: pc_stall = ~(accept | redirect); PC advances exactly once per accepted instruction or redirect.
REQ-025 In WAIT, redirect SHALL set the discard flag.
REQ-026 In REQ, redirect together with imem_gnt SHALL set the discard flag.
REQ-027 The discard flag SHALL be cleared when the discarded response arrives; that response SHALL NOT be written and the next state SHALL be REQ.
REQ-028 Redirect SHALL clear if_valid at the next posedge; if_pc and if_instr SHALL be unchanged.
REQ-029 Redirect SHALL have priority over accept in the same cycle.
REQ-030 When if_valid & id_stall & ~redirect, if_valid, if_pc and if_instr SHALL be held.
REQ-031 When if_valid & ~id_stall & no accept, if_valid<=0 (instruction consumed).
REQ-032 imem_rvalid outside WAIT SHALL be ignored.
REQ-033 imem_gnt outside REQ SHALL be ignored.
REQ-034 pc and addresses SHALL be treated as plain 32-bit values; 32'hFFFF_FFFC SHALL be fetched normally with no wrap handling inside the block.

Reset
REQ-035 rst high SHALL asynchronously force: state=IDLE, discard=0, if_valid=0, if_pc=RESET_PC, if_instr=32'h0000_0013 (NOP), req_pc=0.
REQ-036 While rst is high, imem_req=0 and pc_stall=1.
REQ-037 Reset mid-request SHALL abandon the outstanding access; a stale imem_rvalid in the first cycle after reset SHALL be ignored (IDLE).

Structure
REQ-038 The state encoding (IDLE/REQ/WAIT), the NOP constant and the RESET_PC default SHALL live in the shared CPU package.
REQ-039 The IF/ID holding register (if_valid/if_pc/if_instr with load/hold/clear) SHALL be one sub-module, if_id_reg; the FSM and discard logic SHALL stay in if_fetch.

Verification
REQ-040 The bench SHALL cover: zero-wait memory (gnt same cycle, rvalid next cycle), pc 0,4,8 -> if_instr sequence in order, one instruction per 2 cycles, pc_stall low only on accept cycles.
REQ-041 The bench SHALL cover: 3-cycle rvalid latency -> pc_stall high 3 cycles and imem_addr stable at req_pc throughout WAIT.
REQ-042 The bench SHALL cover: redirect in WAIT with pc=0x100 -> the in-flight response for 0x8 is dropped, if_valid=0, and the next request addr=0x100.
REQ-043 The bench SHALL cover: id_stall=1 with if_valid=1 when the response arrives -> if_instr is unchanged, the request is re-issued with the same address after id_stall drops, and PC does not advance twice.
REQ-044 The bench SHALL cover: redirect and accept in the same cycle -> no write, if_valid=0, pc_stall=0.
REQ-045 The bench SHALL cover: rst asserted in WAIT followed by a stray imem_rvalid -> if_valid=0, if_pc=RESET_PC, and the first request after IDLE has addr=pc.

Source files
------------

// File: rtl/if_fetch_pkg.sv
// Shared CPU front-end definitions: fetch FSM encoding, NOP word and reset PC.
package if_fetch_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } fetch_state_e;

  // addi x0, x0, 0 -- loaded into the IF/ID register on reset
  localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  // The IF/ID slot can take a new word when empty or when decode is draining it.
  function automatic logic calc_slot_free(input logic valid, input logic stall);
    return (~valid) | (~stall);
  endfunction

endpackage

// File: rtl/if_id_reg.sv
// IF/ID holding register: load a fetched word, clear on consume/redirect, else hold.
module if_id_reg
  import if_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load_i,
  input  logic        clear_i,
  input  logic [31:0] pc_i,
  input  logic [31:0] instr_i,
  output logic        valid_o,
  output logic [31:0] pc_o,
  output logic [31:0] instr_o
);

  logic        valid_q, valid_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;

  // Next-state: load wins over clear; a clear drops only the valid bit.
  always_comb begin
    valid_d = valid_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    if (load_i) begin
      valid_d = 1'b1;
      pc_d    = pc_i;
      instr_d = instr_i;
    end else if (clear_i) begin
      valid_d = 1'b0;
    end else begin
      valid_d = valid_q;
    end
  end

  // Holding register with asynchronous reset to an empty NOP slot.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      pc_q    <= RESET_PC;
      instr_q <= NOP_INSTR;
    end else begin
      valid_q <= valid_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
    end
  end

  assign valid_o = valid_q;
  assign pc_o    = pc_q;
  assign instr_o = instr_q;

endmodule

// File: rtl/if_fetch.sv
// Instruction fetch: single-outstanding request FSM with redirect discard
// and back-pressure from decode through the IF/ID register.
module if_fetch
  import if_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc,
  input  logic        redirect,
  input  logic        id_stall,
  output logic        pc_stall,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        if_valid,
  output logic [31:0] if_pc,
  output logic [31:0] if_instr
);

  fetch_state_e state_q, state_d;
  logic         discard_q, discard_d;
  logic [31:0]  req_pc_q, req_pc_d;

  logic slot_free_s;
  logic accept_s;
  logic load_s;
  logic clear_s;

  assign slot_free_s = calc_slot_free(if_valid, id_stall);
  assign accept_s    = (state_q == WAIT) & imem_rvalid & ~discard_q & slot_free_s;
  // Redirect beats accept: the PC still moves once, but the word is not kept.
  assign load_s      = accept_s & ~redirect;
  assign clear_s     = redirect | ~id_stall;

  assign pc_stall  = rst | ~(accept_s | redirect);
  assign imem_req  = (state_q == REQ) & ~rst;
  assign imem_addr = (state_q == WAIT) ? req_pc_q : pc;

  // Next-state: any response in WAIT (kept, dropped for stall, or discarded)
  // returns to REQ; the PC only advanced if it was accepted.
  always_comb begin
    state_d   = state_q;
    discard_d = discard_q;
    req_pc_d  = req_pc_q;
    case (state_q)
      IDLE: begin
        state_d = REQ;
      end
      REQ: begin
        if (imem_gnt) begin
          req_pc_d  = pc;
          state_d   = WAIT;
          discard_d = redirect;
        end else begin
          state_d = REQ;
        end
      end
      WAIT: begin
        if (imem_rvalid) begin
          state_d   = REQ;
          discard_d = 1'b0;
        end else if (redirect) begin
          discard_d = 1'b1;
        end else begin
          discard_d = discard_q;
        end
      end
      default: begin
        state_d   = IDLE;
        discard_d = 1'b0;
      end
    endcase
  end

  // FSM, discard flag and in-flight address registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      discard_q <= 1'b0;
      req_pc_q  <= 32'h0000_0000;
    end else begin
      state_q   <= state_d;
      discard_q <= discard_d;
      req_pc_q  <= req_pc_d;
    end
  end

  if_id_reg #(
    .RESET_PC (RESET_PC)
  ) u_if_id_reg (
    .clk     (clk),
    .rst     (rst),
    .load_i  (load_s),
    .clear_i (clear_s),
    .pc_i    (req_pc_q),
    .instr_i (imem_rdata),
    .valid_o (if_valid),
    .pc_o    (if_pc),
    .instr_o (if_instr)
  );

endmodule

// File: tb/tb_if_fetch.sv
// Directed bench for if_fetch: bench-side PC register and latency-configurable memory.
module tb_if_fetch;

  localparam logic [31:0] RST_PC = 32'h0000_0040;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc;
  logic        redirect;
  logic        id_stall;
  logic        pc_stall;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] if_instr;

  logic [31:0] redir_pc;
  logic [31:0] raddr;
  int          lat;
  int          cnt;
  int          n_cmp = 0;
  int          n_bad = 0;

  if_fetch #(.RESET_PC(RST_PC)) dut (
    .clk         (clk),
    .rst         (rst),
    .pc          (pc),
    .redirect    (redirect),
    .id_stall    (id_stall),
    .pc_stall    (pc_stall),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_gnt    (imem_gnt),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .if_valid    (if_valid),
    .if_pc       (if_pc),
    .if_instr    (if_instr)
  );

  always #5 clk = ~clk;

  // Memory content: word = address ^ 5A5A_0000
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'h5A5A_0000;
  endfunction

  // One clock: PC register update, memory response pipeline; leaves time at edge+2.
  task automatic tick();
    logic        adv;
    logic        redir;
    logic        issue;
    logic [31:0] a;
    logic [31:0] tgt;
    adv   = ~pc_stall;
    redir = redirect;
    tgt   = redir_pc;
    issue = imem_req & imem_gnt;
    a     = imem_addr;
    @(posedge clk);
    #1;
    if (adv) pc = redir ? tgt : pc + 32'd4;
    imem_rvalid = 1'b0;
    if (issue) begin
      cnt   = lat;
      raddr = a;
    end
    if (cnt > 0) begin
      cnt = cnt - 1;
      if (cnt == 0) begin
        imem_rvalid = 1'b1;
        imem_rdata  = mem_word(raddr);
      end
    end
    #1;
  endtask

  task automatic do_reset(input logic [31:0] start);
    rst = 1'b1; redirect = 1'b0; id_stall = 1'b0; imem_rvalid = 1'b0;
    imem_rdata = 32'h0; imem_gnt = 1'b1; cnt = 0; lat = 1; pc = start; redir_pc = 32'h0;
    #1;
    tick();
    tick();
    rst = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; redirect = 1'b1; id_stall = 1'b0; imem_rvalid = 1'b0; imem_rdata = 32'h0;
    imem_gnt = 1'b1; cnt = 0; lat = 1; pc = RST_PC; redir_pc = 32'h0;
    #1;
    n_cmp++; if (imem_req !== 1'b0) begin n_bad++; $display("FAIL rst_req: got %b want 0", imem_req); end
    n_cmp++; if (pc_stall !== 1'b1) begin n_bad++; $display("FAIL rst_pc_stall: got %b want 1", pc_stall); end
    n_cmp++; if (if_valid !== 1'b0) begin n_bad++; $display("FAIL rst_valid: got %b want 0", if_valid); end
    n_cmp++; if (if_pc !== 32'h0000_0040) begin n_bad++; $display("FAIL rst_if_pc: got %h want 00000040", if_pc); end
    n_cmp++; if (if_instr !== 32'h0000_0013) begin n_bad++; $display("FAIL rst_if_instr: got %h want 00000013", if_instr); end
    redirect = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    #1;
    n_cmp++; if (imem_req !== 1'b0) begin n_bad++; $display("FAIL rst_idle_req: got %b want 0", imem_req); end
    tick();
    n_cmp++; if (imem_req !== 1'b1) begin n_bad++; $display("FAIL rst_first_req: got %b want 1", imem_req); end
    n_cmp++; if (imem_addr !== 32'h0000_0040) begin n_bad++; $display("FAIL rst_first_addr: got %h want 00000040", imem_addr); end
  endtask

  task automatic test_zero_wait();
    logic [31:0] exp_a [3] = '{32'h0000_0000, 32'h0000_0004, 32'h0000_0008};
    logic [31:0] exp_i [3] = '{32'h5A5A_0000, 32'h5A5A_0004, 32'h5A5A_0008};
    do_reset(32'h0000_0000);
    tick();
    for (int k = 0; k < 3; k++) begin
      n_cmp++; if (imem_req !== 1'b1) begin n_bad++; $display("FAIL zw_req[%0d]: got %b want 1", k, imem_req); end
      n_cmp++; if (imem_addr !== exp_a[k]) begin n_bad++; $display("FAIL zw_addr[%0d]: got %h want %h", k, imem_addr, exp_a[k]); end
      n_cmp++; if (pc_stall !== 1'b1) begin n_bad++; $display("FAIL zw_stall_req[%0d]: got %b want 1", k, pc_stall); end
      tick();
      n_cmp++; if (imem_req !== 1'b0) begin n_bad++; $display("FAIL zw_req_wait[%0d]: got %b want 0", k, imem_req); end
      n_cmp++; if (pc_stall !== 1'b0) begin n_bad++; $display("FAIL zw_stall_acc[%0d]: got %b want 0", k, pc_stall); end
      tick();
      n_cmp++; if (if_valid !== 1'b1) begin n_bad++; $display("FAIL zw_valid[%0d]: got %b want 1", k, if_valid); end
      n_cmp++; if (if_pc !== exp_a[k]) begin n_bad++; $display("FAIL zw_if_pc[%0d]: got %h want %h", k, if_pc, exp_a[k]); end
      n_cmp++; if (if_instr !== exp_i[k]) begin n_bad++; $display("FAIL zw_instr[%0d]: got %h want %h", k, if_instr, exp_i[k]); end
    end
  endtask

  task automatic test_latency();
    int stalls;
    do_reset(32'h0000_0000);
    lat = 3;
    tick();
    stalls = 0;
    n_cmp++; if (imem_req !== 1'b1) begin n_bad++; $display("FAIL lat_req: got %b want 1", imem_req); end
    if (pc_stall === 1'b1) stalls++;
    tick();
    for (int w = 0; w < 2; w++) begin
      n_cmp++; if (imem_addr !== 32'h0000_0000) begin n_bad++; $display("FAIL lat_addr[%0d]: got %h want 00000000", w, imem_addr); end
      n_cmp++; if (imem_req !== 1'b0) begin n_bad++; $display("FAIL lat_req_wait[%0d]: got %b want 0", w, imem_req); end
      if (pc_stall === 1'b1) stalls++;
      tick();
    end
    n_cmp++; if (imem_addr !== 32'h0000_0000) begin n_bad++; $display("FAIL lat_addr_rsp: got %h want 00000000", imem_addr); end
    n_cmp++; if (pc_stall !== 1'b0) begin n_bad++; $display("FAIL lat_stall_acc: got %b want 0", pc_stall); end
    n_cmp++; if (stalls !== 3) begin n_bad++; $display("FAIL lat_stall_cycles: got %0d want 3", stalls); end
    lat = 1;
    tick();
    n_cmp++; if (if_instr !== 32'h5A5A_0000) begin n_bad++; $display("FAIL lat_instr: got %h want 5a5a0000", if_instr); end
    n_cmp++; if (pc !== 32'h0000_0004) begin n_bad++; $display("FAIL lat_pc_adv: got %h want 00000004", pc); end
  endtask

  task automatic test_redirect_wait();
    do_reset(32'h0000_0000);
    tick(); tick(); tick(); tick(); tick();
    id_stall = 1'b1; lat = 3;
    #1;
    n_cmp++; if (imem_addr !== 32'h0000_0008) begin n_bad++; $display("FAIL rw_addr8: got %h want 00000008", imem_addr); end
    n_cmp++; if (if_valid !== 1'b1) begin n_bad++; $display("FAIL rw_valid_pre: got %b want 1", if_valid); end
    tick();
    redirect = 1'b1; redir_pc = 32'h0000_0100;
    #1;
    n_cmp++; if (pc_stall !== 1'b0) begin n_bad++; $display("FAIL rw_stall_redir: got %b want 0", pc_stall); end
    tick();
    redirect = 1'b0;
    #1;
    n_cmp++; if (if_valid !== 1'b0) begin n_bad++; $display("FAIL rw_valid_clr: got %b want 0", if_valid); end
    n_cmp++; if (if_pc !== 32'h0000_0004) begin n_bad++; $display("FAIL rw_if_pc_hold: got %h want 00000004", if_pc); end
    n_cmp++; if (if_instr !== 32'h5A5A_0004) begin n_bad++; $display("FAIL rw_instr_hold: got %h want 5a5a0004", if_instr); end
    n_cmp++; if (imem_req !== 1'b0) begin n_bad++; $display("FAIL rw_req_wait: got %b want 0", imem_req); end
    tick();
    n_cmp++; if (pc_stall !== 1'b1) begin n_bad++; $display("FAIL rw_stall_drop: got %b want 1", pc_stall); end
    lat = 1;
    tick();
    n_cmp++; if (if_valid !== 1'b0) begin n_bad++; $display("FAIL rw_no_write: got %b want 0", if_valid); end
    n_cmp++; if (imem_req !== 1'b1) begin n_bad++; $display("FAIL rw_req_new: got %b want 1", imem_req); end
    n_cmp++; if (imem_addr !== 32'h0000_0100) begin n_bad++; $display("FAIL rw_addr_new: got %h want 00000100", imem_addr); end
    id_stall = 1'b0;
    tick(); tick();
    n_cmp++; if (if_instr !== 32'h5A5A_0100) begin n_bad++; $display("FAIL rw_instr_new: got %h want 5a5a0100", if_instr); end
    n_cmp++; if (if_pc !== 32'h0000_0100) begin n_bad++; $display("FAIL rw_if_pc_new: got %h want 00000100", if_pc); end
  endtask

  task automatic test_id_stall();
    do_reset(32'h0000_0000);
    tick(); tick(); tick();
    id_stall = 1'b1;
    #1;
    n_cmp++; if (imem_addr !== 32'h0000_0004) begin n_bad++; $display("FAIL st_addr4: got %h want 00000004", imem_addr); end
    tick();
    n_cmp++; if (pc_stall !== 1'b1) begin n_bad++; $display("FAIL st_stall_drop: got %b want 1", pc_stall); end
    tick();
    n_cmp++; if (if_instr !== 32'h5A5A_0000) begin n_bad++; $display("FAIL st_instr_hold: got %h want 5a5a0000", if_instr); end
    n_cmp++; if (if_valid !== 1'b1) begin n_bad++; $display("FAIL st_valid_hold: got %b want 1", if_valid); end
    n_cmp++; if (pc !== 32'h0000_0004) begin n_bad++; $display("FAIL st_pc_held: got %h want 00000004", pc); end
    id_stall = 1'b0;
    #1;
    n_cmp++; if (imem_req !== 1'b1) begin n_bad++; $display("FAIL st_reissue_req: got %b want 1", imem_req); end
    n_cmp++; if (imem_addr !== 32'h0000_0004) begin n_bad++; $display("FAIL st_reissue_addr: got %h want 00000004", imem_addr); end
    tick();
    n_cmp++; if (pc_stall !== 1'b0) begin n_bad++; $display("FAIL st_stall_acc: got %b want 0", pc_stall); end
    tick();
    n_cmp++; if (if_instr !== 32'h5A5A_0004) begin n_bad++; $display("FAIL st_instr_new: got %h want 5a5a0004", if_instr); end
    n_cmp++; if (if_pc !== 32'h0000_0004) begin n_bad++; $display("FAIL st_if_pc_new: got %h want 00000004", if_pc); end
    n_cmp++; if (pc !== 32'h0000_0008) begin n_bad++; $display("FAIL st_pc_once: got %h want 00000008", pc); end
  endtask

  task automatic test_redirect_accept();
    do_reset(32'h0000_0000);
    tick(); tick();
    redirect = 1'b1; redir_pc = 32'h0000_0200;
    #1;
    n_cmp++; if (pc_stall !== 1'b0) begin n_bad++; $display("FAIL ra_stall: got %b want 0", pc_stall); end
    tick();
    redirect = 1'b0;
    #1;
    n_cmp++; if (if_valid !== 1'b0) begin n_bad++; $display("FAIL ra_valid: got %b want 0", if_valid); end
    n_cmp++; if (if_instr !== 32'h0000_0013) begin n_bad++; $display("FAIL ra_no_write: got %h want 00000013", if_instr); end
    n_cmp++; if (if_pc !== 32'h0000_0040) begin n_bad++; $display("FAIL ra_if_pc: got %h want 00000040", if_pc); end
    n_cmp++; if (pc !== 32'h0000_0200) begin n_bad++; $display("FAIL ra_pc: got %h want 00000200", pc); end
    n_cmp++; if (imem_req !== 1'b1) begin n_bad++; $display("FAIL ra_req: got %b want 1", imem_req); end
    n_cmp++; if (imem_addr !== 32'h0000_0200) begin n_bad++; $display("FAIL ra_addr: got %h want 00000200", imem_addr); end
    tick(); tick();
    n_cmp++; if (if_instr !== 32'h5A5A_0200) begin n_bad++; $display("FAIL ra_instr_next: got %h want 5a5a0200", if_instr); end
    n_cmp++; if (if_valid !== 1'b1) begin n_bad++; $display("FAIL ra_valid_next: got %b want 1", if_valid); end
  endtask

  task automatic test_top_address();
    do_reset(32'hFFFF_FFFC);
    tick();
    n_cmp++; if (imem_addr !== 32'hFFFF_FFFC) begin n_bad++; $display("FAIL top_addr: got %h want fffffffc", imem_addr); end
    tick(); tick();
    n_cmp++; if (if_pc !== 32'hFFFF_FFFC) begin n_bad++; $display("FAIL top_if_pc: got %h want fffffffc", if_pc); end
    n_cmp++; if (if_instr !== 32'hA5A5_FFFC) begin n_bad++; $display("FAIL top_instr: got %h want a5a5fffc", if_instr); end
  endtask

  task automatic test_reset_mid();
    do_reset(32'h0000_0000);
    tick(); tick(); tick();
    id_stall = 1'b1; lat = 3;
    tick();
    rst = 1'b1;
    #1;
    n_cmp++; if (if_valid !== 1'b0) begin n_bad++; $display("FAIL rm_valid: got %b want 0", if_valid); end
    n_cmp++; if (if_pc !== 32'h0000_0040) begin n_bad++; $display("FAIL rm_if_pc: got %h want 00000040", if_pc); end
    n_cmp++; if (if_instr !== 32'h0000_0013) begin n_bad++; $display("FAIL rm_instr: got %h want 00000013", if_instr); end
    n_cmp++; if (imem_req !== 1'b0) begin n_bad++; $display("FAIL rm_req: got %b want 0", imem_req); end
    n_cmp++; if (pc_stall !== 1'b1) begin n_bad++; $display("FAIL rm_stall: got %b want 1", pc_stall); end
    cnt = 0; lat = 1; pc = RST_PC;
    tick();
    rst = 1'b0; id_stall = 1'b0;
    imem_rvalid = 1'b1; imem_rdata = 32'hDEAD_BEEF;
    #1;
    n_cmp++; if (imem_req !== 1'b0) begin n_bad++; $display("FAIL rm_idle_req: got %b want 0", imem_req); end
    n_cmp++; if (pc_stall !== 1'b1) begin n_bad++; $display("FAIL rm_idle_stall: got %b want 1", pc_stall); end
    tick();
    n_cmp++; if (if_valid !== 1'b0) begin n_bad++; $display("FAIL rm_stray_valid: got %b want 0", if_valid); end
    n_cmp++; if (if_instr !== 32'h0000_0013) begin n_bad++; $display("FAIL rm_stray_instr: got %h want 00000013", if_instr); end
    n_cmp++; if (imem_req !== 1'b1) begin n_bad++; $display("FAIL rm_first_req: got %b want 1", imem_req); end
    n_cmp++; if (imem_addr !== 32'h0000_0040) begin n_bad++; $display("FAIL rm_first_addr: got %h want 00000040", imem_addr); end
  endtask

  // Guard against a hung run.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish within 200000 time units");
    $fatal(1, "timeout");
  end

  // Scenario sequence and summary.
  initial begin
    test_reset();
    test_zero_wait();
    test_latency();
    test_redirect_wait();
    test_id_stall();
    test_redirect_accept();
    test_top_address();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
